// File: rtl/timer32.sv
// timer32 : prescaled up-counter timer core.
//
// A prescaler divides PCLK by PRE+1 to produce a one-cycle tick. On each tick
// the count TMR increments, or wraps to 0 when it has reached TMRCMP. A wrap
// sets the sticky flag TMROV. A rising edge on TMROVCLR clears TMROV.
//
// Ports:
//   PCLK      in   clock
//   PRESETn   in   asynchronous active-low reset
//   TMREN     in   timer enable (level); low stops and clears TMR and prescaler
//   PRE       in   prescale terminal value, tick period = PRE+1 cycles
//   TMRCMP    in   compare/reload terminal value for TMR
//   TMROVCLR  in   overflow clear request, acts on its 0->1 edge only
//   TMR       out  current count (registered)
//   TMROV     out  sticky overflow/match flag (registered)
//
// There is no handshake. PRE and TMRCMP are not shadowed and are compared
// live, so a change takes effect at the next comparison.
module timer32 #(
   parameter int WIDTH = 32
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             TMREN,
   input  logic [WIDTH-1:0] PRE,
   input  logic [WIDTH-1:0] TMRCMP,
   input  logic             TMROVCLR,
   output logic [WIDTH-1:0] TMR,
   output logic             TMROV
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] pre_cnt;
   logic             clr_q;
   logic             tick;
   logic             ovf_set;
   logic             clr_pulse;

   // >= instead of ==: when PRE is lowered below the running prescale count,
   // the prescaler ends on the next edge and does not wrap through 2^WIDTH.
   assign tick      = TMREN & (pre_cnt >= PRE);
   // The same reasoning applies to TMRCMP. A lowered compare value wraps TMR
   // on the next tick.
   assign ovf_set   = tick & (TMR >= TMRCMP);
   assign clr_pulse = TMROVCLR & ~clr_q;

   // Prescaler
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         pre_cnt <= '0;
      end else if (!TMREN || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + ONE;
      end
   end

   // Counter. Disabling clears the count and leaves TMROV alone.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         TMR <= '0;
      end else if (!TMREN) begin
         TMR <= '0;
      end else if (ovf_set) begin
         TMR <= '0;
      end else if (tick) begin
         TMR <= TMR + ONE;
      end
   end

   // Sticky flag. A set wins over a simultaneous clear so that no event is
   // lost. A TMROVCLR held high produces no further pulses, so it cannot
   // block later sets.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         clr_q <= 1'b0;
         TMROV <= 1'b0;
      end else begin
         clr_q <= TMROVCLR;
         if (ovf_set) begin
            TMROV <= 1'b1;
         end else if (clr_pulse) begin
            TMROV <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_timer32.sv
module tb_timer32;

   logic        PCLK;
   logic        PRESETn;
   logic        TMREN;
   logic [31:0] PRE;
   logic [31:0] TMRCMP;
   logic        TMROVCLR;
   logic [31:0] TMR;
   logic        TMROV;

   int checks   = 0;
   int failures = 0;

   // Scoreboard entries are {TMROV, TMR}.
   logic [32:0] exp_q[$];

   timer32 #(.WIDTH(32)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .TMREN   (TMREN),
      .PRE     (PRE),
      .TMRCMP  (TMRCMP),
      .TMROVCLR(TMROVCLR),
      .TMR     (TMR),
      .TMROV   (TMROV)
   );

   // clock / reset
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // scoreboard
   task automatic check_now(input string tag);
      logic [32:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         assert ({TMROV, TMR} === e) else begin
            failures++;
            $error("FAIL %s: observed TMR=%0d TMROV=%0b expected TMR=%0d TMROV=%0b",
                   tag, TMR, TMROV, e[31:0], e[32]);
         end
      end
   endtask

   // Push the expectation, advance n edges, then sample 1 time unit after the edge.
   task automatic run_check(input string tag, input int n,
                            input logic [31:0] e_tmr, input logic e_ov);
      exp_q.push_back({e_ov, e_tmr});
      repeat (n) @(posedge PCLK);
      #1;
      check_now(tag);
   endtask

   initial begin
      PRESETn  = 1'b0;
      TMREN    = 1'b0;
      PRE      = '0;
      TMRCMP   = '0;
      TMROVCLR = 1'b0;
      exp_q.push_back({1'b0, 32'd0});
      repeat (2) @(posedge PCLK);
      #1;
      check_now("reset_state");
      PRESETn = 1'b1;

      // Prescale: PRE=3 gives TMR=1 after edge 4, 2 after edge 8, 10 after edge 40.
      PRE    = 32'd3;
      TMRCMP = 32'hFFFF_FFFF;
      TMREN  = 1'b1;
      run_check("pre_edge3", 3, 32'd0, 1'b0);
      run_check("pre_edge4", 1, 32'd1, 1'b0);
      run_check("pre_edge8", 4, 32'd2, 1'b0);
      run_check("pre_edge40", 32, 32'd10, 1'b0);
      TMREN = 1'b0;
      run_check("pre_disable", 1, 32'd0, 1'b0);

      // Match/wrap: PRE=0, TMRCMP=4 gives 1,2,3,4,0,1 and TMROV rises at the wrap.
      PRE    = 32'd0;
      TMRCMP = 32'd4;
      TMREN  = 1'b1;
      for (int i = 1; i <= 4; i++) run_check("wrap_up", 1, 32'(i), 1'b0);
      run_check("wrap_zero", 1, 32'd0, 1'b1);
      run_check("wrap_after", 1, 32'd1, 1'b1);
      run_check("wrap_e7", 1, 32'd2, 1'b1);
      run_check("wrap_e8", 1, 32'd3, 1'b1);
      run_check("wrap_e9", 1, 32'd4, 1'b1);

      // A clear edge on the same edge as a wrap: the set wins.
      TMROVCLR = 1'b1;
      run_check("clr_vs_wrap", 1, 32'd0, 1'b1);
      TMROVCLR = 1'b0;
      run_check("clr_low", 1, 32'd1, 1'b1);
      TMROVCLR = 1'b1;
      run_check("clr_pulse", 1, 32'd2, 1'b0);
      // TMROVCLR stays high, so the next wrap must set the flag again.
      run_check("clr_held_e13", 1, 32'd3, 1'b0);
      run_check("clr_held_e14", 1, 32'd4, 1'b0);
      run_check("clr_held_wrap", 1, 32'd0, 1'b1);
      TMROVCLR = 1'b0;

      // Disable at TMR=3 clears TMR and keeps TMROV. Re-enable with PRE=1.
      run_check("en_e16", 3, 32'd3, 1'b1);
      TMREN = 1'b0;
      run_check("dis_clear", 1, 32'd0, 1'b1);
      PRE   = 32'd1;
      TMREN = 1'b1;
      run_check("reen_edge1", 1, 32'd0, 1'b1);
      run_check("reen_edge2", 1, 32'd1, 1'b1);

      // Clear the flag while disabled. Then raise TMR to 10 and lower TMRCMP to 5.
      TMREN    = 1'b0;
      TMROVCLR = 1'b1;
      run_check("dis_and_clr", 1, 32'd0, 1'b0);
      TMROVCLR = 1'b0;
      PRE      = 32'd0;
      TMRCMP   = 32'd100;
      TMREN    = 1'b1;
      run_check("dyn_reach10", 10, 32'd10, 1'b0);
      TMRCMP = 32'd5;
      run_check("dyn_cmp_lower", 1, 32'd0, 1'b1);

      // Lower PRE from 100 to 2 while pre_cnt=50: the tick comes on the next edge.
      PRE    = 32'd100;
      TMRCMP = 32'hFFFF_FFFF;
      run_check("dyn_pre_wait", 50, 32'd0, 1'b1);
      PRE = 32'd2;
      run_check("dyn_pre_lower", 1, 32'd1, 1'b1);

      // TMRCMP=0: TMR goes to 0 and stays there.
      PRE    = 32'd0;
      TMRCMP = 32'd0;
      run_check("cmp0_a", 1, 32'd0, 1'b1);
      run_check("cmp0_b", 1, 32'd0, 1'b1);

      // Asynchronous reset in the middle of a count at TMR=5, TMROV=1.
      TMRCMP = 32'd100;
      run_check("rst_pre", 5, 32'd5, 1'b1);
      #2;
      PRESETn = 1'b0;
      exp_q.push_back({1'b0, 32'd0});
      #1;
      check_now("rst_async");
      #1;
      PRESETn = 1'b1;
      run_check("rst_resume", 1, 32'd1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
